// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the conditional modular subtraction and the
// byte-encoder state type.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;

  // A single subtraction is enough: the largest 12-bit input is below 2*Q.
  function automatic logic [COEF_W-1:0] cond_sub_q(input logic [COEF_W-1:0] c);
    if (c >= COEF_W'(KYBER_Q)) begin
      return c - COEF_W'(KYBER_Q);
    end
    return c;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EMIT0  = 3'd3,
    ST_EMIT1  = 3'd4,
    ST_EMIT2  = 3'd5,
    ST_DONE   = 3'd6
  } enc_state_t;

endpackage

// File: rtl/coef_reduce.sv
// Combinational reduction of a 12-bit coefficient into [0, Q).
module coef_reduce
  import kyber_pkg::*;
(
  input  logic [COEF_W-1:0] i_coef,
  output logic [COEF_W-1:0] o_coef_red
);

  assign o_coef_red = cond_sub_q(i_coef);

endmodule

// File: rtl/byte_encode12.sv
// Streaming packer: reduces coefficient pairs and emits each pair as three
// little-endian bytes.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; valid never depends on ready, and the payload is held stable
// while valid is high and ready is low.
module byte_encode12
  import kyber_pkg::*;
#(
  parameter int N = KYBER_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done,
  output enc_state_t        dbg_state
);

  localparam int PAIRS = N / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(PAIRS - 1);

  enc_state_t          r_state;
  enc_state_t          w_next;
  logic [CW-1:0]       r_pair_cnt;
  logic [2*COEF_W-1:0] r_pair;
  logic                r_coef_ready;
  logic                r_byte_valid;
  logic                r_busy;
  logic                r_done;
  logic [COEF_W-1:0]   w_coef_red;
  logic                w_coef_hs;
  logic                w_byte_hs;

  coef_reduce u_coef_reduce (
    .i_coef     (coef_data),
    .o_coef_red (w_coef_red)
  );

  assign w_coef_hs = coef_valid & r_coef_ready;
  assign w_byte_hs = r_byte_valid & byte_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start)     w_next = ST_LOAD_A;
      ST_LOAD_A:        if (w_coef_hs) w_next = ST_LOAD_B;
      ST_LOAD_B:        if (w_coef_hs) w_next = ST_EMIT0;
      ST_EMIT0:         if (w_byte_hs) w_next = ST_EMIT1;
      ST_EMIT1:         if (w_byte_hs) w_next = ST_EMIT2;
      ST_EMIT2: begin
        if (w_byte_hs) w_next = (r_pair_cnt == LAST_PAIR) ? ST_DONE : ST_LOAD_A;
      end
      default:          w_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pair_cnt   <= '0;
      r_pair       <= '0;
      r_coef_ready <= 1'b0;
      r_byte_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_coef_ready <= (w_next == ST_LOAD_A) || (w_next == ST_LOAD_B);
      r_byte_valid <= (w_next == ST_EMIT0) || (w_next == ST_EMIT1) || (w_next == ST_EMIT2);
      r_busy       <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      r_done       <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE, ST_DONE: if (start) r_pair_cnt <= '0;
        ST_LOAD_A: if (w_coef_hs) r_pair[COEF_W-1:0]        <= w_coef_red;
        ST_LOAD_B: if (w_coef_hs) r_pair[2*COEF_W-1:COEF_W] <= w_coef_red;
        ST_EMIT2: begin
          if (w_byte_hs && (r_pair_cnt != LAST_PAIR)) r_pair_cnt <= r_pair_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // {a1, a0} laid out so each output byte is a plain byte slice.
  always_comb begin
    case (r_state)
      ST_EMIT0: byte_data = r_pair[7:0];
      ST_EMIT1: byte_data = r_pair[15:8];
      ST_EMIT2: byte_data = r_pair[23:16];
      default:  byte_data = 8'h00;
    endcase
  end

  assign coef_ready = r_coef_ready;
  assign byte_valid = r_byte_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule
